alu_control_mdu: RTL and testbench
==================================

Name: alu_control_mdu

Overview:
- Successor to the combinational ALU control decoder for the EX stage of the 5-stage MIPS core.
- Keeps the same ALU-op decode contract, generalised by parameters, with explicit illegal-op signalling.
- Adds an iterative multiply/divide unit (MULT/MULTU/DIV/DIVU), HI/LO registers, MFHI/MFLO/MTHI/MTLO, and a pipeline stall handshake.

Parameters:
- NBITS, 32, operand width; HI/LO width; multiply/divide iteration count.
- ANBITS, 6, width of funct and opcode fields.
- NBITSCONTROL, 2, width of the main-control ALUOp class.
- ALUOP, 4, width of the ALU operation code.

Ports:
- i_clk  in  1  clock, rising edge.
- i_reset_n  in  1  asynchronous, active-low reset.
- i_Valid  in  1  EX holds a real instruction (not a bubble).
- i_Flush  in  1  synchronous abort of an in-flight multiply/divide.
- i_Funct  in  ANBITS  instruction funct field.
- i_Opcode  in  ANBITS  instruction opcode.
- i_ALUOp  in  NBITSCONTROL  class from main control: 00 add, 01 sub, 10 R-type, 11 immediate.
- i_RS  in  NBITS  rs operand.
- i_RT  in  NBITS  rt operand.
- o_ALUOp  out  ALUOP  ALU operation code.
- o_Illegal  out  1  funct/opcode not decodable for the class.
- o_Stall  out  1  freeze PC, IF/ID and ID/EX.
- o_HiLoSel  out  1  EX result comes from o_HiLo (MFHI/MFLO).
- o_HiLo  out  NBITS  HI for MFHI, LO for MFLO.
- o_DivByZero  out  1  one-cycle pulse in DONE when the divisor was 0.

Behaviour:
- Reset (asynchronous, i_reset_n low): state IDLE, HI=0, LO=0, counter=0, o_Stall=0, o_DivByZero=0. All outputs return to reset values within the same cycle, including mid-operation.
- Decode (combinational):
  - 00 -> 0010; 01 -> 0110.
  - 10, by funct: ADD/ADDU 0010, SUB/SUBU 0110, AND 0000, OR 0001, NOR 1100, XOR 1101, SLT 0111, SLL/SLLV 0011, SRL/SRLV 0100, SRA 1001.
  - 11, by opcode: SLTI 0111, ANDI 0000, ORI 0001, XORI 1101.
  - MDU functs (MULT 011000, MULTU 011001, DIV 011010, DIVU 011011, MFHI 010000, MTHI 010001, MFLO 010010, MTLO 010011): o_ALUOp=0010, o_Illegal=0.
  - Any other code: o_ALUOp=1111, o_Illegal=1. o_Illegal is forced 0 when i_Valid=0.
- start = i_Valid && i_ALUOp==10 && funct is one of MULT/MULTU/DIV/DIVU.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - If start: o_Stall=1 combinationally.
  - At the clock edge, latch magnitudes (signed ops take absolute values), latch result-sign flags, counter=NBITS, go to BUSY.
  - DIV/DIVU with i_RT==0 go directly to DONE.
- BUSY:
  - o_Stall=1.
  - One shift-add (multiply) or one restoring-subtract (divide) step per cycle; counter decrements.
  - When counter reaches 1: write HI/LO with sign correction applied, go to DONE.
- DONE:
  - o_Stall=0, so the instruction leaves EX. start is ignored in this state. Next state is IDLE.
  - o_DivByZero=1 only in DONE after a zero-divisor entry.
- Stall length: NBITS+1 cycles for a normal op; 1 cycle for divide-by-zero.
- Results:
  - MULT/MULTU: {HI,LO} = 2*NBITS-bit product. Signed product is negated when operand signs differ.
  - DIV/DIVU: LO = quotient, HI = remainder. Signed quotient is negated when signs differ; remainder takes the dividend's sign.
  - Most-negative / -1 gives LO=100..0, HI=0.
  - Divide by zero: HI = dividend, LO = all ones.
- Flush: i_Flush in BUSY or DONE -> IDLE at the edge; HI/LO unchanged; i_Flush has priority over completion.
- MTHI/MTLO: in IDLE with i_Valid, HI or LO <= i_RS at the edge.
- MFHI/MFLO: o_HiLoSel=1; o_HiLo = HI or LO, combinational from the registers.

Decomposition:
- Shared package (mips_pkg) holds:
  - funct/opcode constants;
  - the ALU-op encodings, including ALU_ILLEGAL=1111;
  - the ALUOp class constants;
  - the MDU state encoding.
- Sub-module mdu_datapath holds the operand/product/remainder shift registers and the add/subtract step.
- alu_control_mdu keeps the decoder, FSM, counter and HI/LO.

Test Plan:
- Decode sweep: every defined funct/opcode -> listed code. funct 111111 with class 10 -> o_ALUOp=1111, o_Illegal=1.
- MULTU 0xFFFFFFFF x 0x00000002 -> o_Stall high for exactly 33 cycles; then HI=0x00000001, LO=0xFFFFFFFE; MFHI/MFLO return these values.
- MULT -3 x 5 -> HI=0xFFFFFFFF, LO=0xFFFFFFF1. DIV -7 / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU 0x12345678 / 0 -> stall 1 cycle, o_DivByZero pulse, HI=0x12345678, LO=0xFFFFFFFF.
- DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- Reset asserted at BUSY iteration 10 -> o_Stall=0, HI=LO=0 immediately. i_Flush at iteration 10 -> IDLE next cycle, previous HI/LO preserved.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS EX-stage definitions: funct/opcode field values, ALU operation
// codes, the main-control ALUOp classes and the multiply/divide FSM states.
package mips_pkg;

  // R-type funct field values
  localparam logic [5:0] F_SLL   = 6'b000000;
  localparam logic [5:0] F_SRL   = 6'b000010;
  localparam logic [5:0] F_SRA   = 6'b000011;
  localparam logic [5:0] F_SLLV  = 6'b000100;
  localparam logic [5:0] F_SRLV  = 6'b000110;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MTLO  = 6'b010011;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_ADD   = 6'b100000;
  localparam logic [5:0] F_ADDU  = 6'b100001;
  localparam logic [5:0] F_SUB   = 6'b100010;
  localparam logic [5:0] F_SUBU  = 6'b100011;
  localparam logic [5:0] F_AND   = 6'b100100;
  localparam logic [5:0] F_OR    = 6'b100101;
  localparam logic [5:0] F_XOR   = 6'b100110;
  localparam logic [5:0] F_NOR   = 6'b100111;
  localparam logic [5:0] F_SLT   = 6'b101010;

  // I-type opcodes decoded by the immediate class
  localparam logic [5:0] OP_SLTI = 6'b001010;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_XORI = 6'b001110;

  // ALU operation codes
  localparam logic [3:0] ALU_AND     = 4'b0000;
  localparam logic [3:0] ALU_OR      = 4'b0001;
  localparam logic [3:0] ALU_ADD     = 4'b0010;
  localparam logic [3:0] ALU_SLL     = 4'b0011;
  localparam logic [3:0] ALU_SRL     = 4'b0100;
  localparam logic [3:0] ALU_SUB     = 4'b0110;
  localparam logic [3:0] ALU_SLT     = 4'b0111;
  localparam logic [3:0] ALU_SRA     = 4'b1001;
  localparam logic [3:0] ALU_NOR     = 4'b1100;
  localparam logic [3:0] ALU_XOR     = 4'b1101;
  localparam logic [3:0] ALU_ILLEGAL = 4'b1111;

  // ALUOp class from main control
  localparam logic [1:0] CLS_ADD   = 2'b00;
  localparam logic [1:0] CLS_SUB   = 2'b01;
  localparam logic [1:0] CLS_RTYPE = 2'b10;
  localparam logic [1:0] CLS_IMM   = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_DONE = 2'b10
  } mdu_state_t;

endpackage

// File: rtl/mdu_datapath.sv
// Iterative multiply/divide datapath on unsigned magnitudes.
//   clk    : clock, rising edge
//   load   : capture a_mag/b_mag and clear the upper accumulator
//   step   : perform one shift-add (multiply) or restoring-subtract (divide)
//   is_div : selects divide step
//   a_mag  : multiplier / dividend magnitude
//   b_mag  : multiplicand / divisor magnitude
//   nxt_hi : upper half after the step being taken this cycle (product high / remainder)
//   nxt_lo : lower half after the step being taken this cycle (product low / quotient)
module mdu_datapath #(
  parameter int NBITS = 32
) (
  input  logic             clk,
  input  logic             load,
  input  logic             step,
  input  logic             is_div,
  input  logic [NBITS-1:0] a_mag,
  input  logic [NBITS-1:0] b_mag,
  output logic [NBITS-1:0] nxt_hi,
  output logic [NBITS-1:0] nxt_lo
);

  // hi_r carries one extra bit: the multiply carry-out or the divide borrow.
  logic [NBITS:0]   hi_r;
  logic [NBITS-1:0] lo_r;
  logic [NBITS-1:0] b_r;

  logic [NBITS:0]   hi_nx;
  logic [NBITS-1:0] lo_nx;
  logic [NBITS:0]   sum;
  logic [NBITS:0]   shl;
  logic [NBITS:0]   diff;

  always_comb begin
    sum  = hi_r + {1'b0, b_r};
    shl  = {hi_r[NBITS-1:0], lo_r[NBITS-1]};
    diff = shl - {1'b0, b_r};
    hi_nx = hi_r;
    lo_nx = lo_r;
    if (is_div) begin
      // Remainder stays below the divisor, so bit NBITS of diff is a pure borrow flag.
      if (!diff[NBITS]) begin
        hi_nx = diff;
        lo_nx = {lo_r[NBITS-2:0], 1'b1};
      end else begin
        hi_nx = shl;
        lo_nx = {lo_r[NBITS-2:0], 1'b0};
      end
    end else begin
      {hi_nx, lo_nx} = {(lo_r[0] ? sum : hi_r), lo_r} >> 1;
    end
  end

  always_ff @(posedge clk) begin
    if (load) begin
      hi_r <= '0;
      lo_r <= a_mag;
      b_r  <= b_mag;
    end else if (step) begin
      hi_r <= hi_nx;
      lo_r <= lo_nx;
    end
  end

  assign nxt_hi = hi_nx[NBITS-1:0];
  assign nxt_lo = lo_nx;

endmodule

// File: rtl/alu_control_mdu.sv
// EX-stage ALU control decoder with iterative multiply/divide unit and HI/LO.
//   i_clk, i_reset_n : clock (rising edge), asynchronous active-low reset
//   i_Valid, i_Flush : real instruction in EX; abort in-flight multiply/divide
//   i_Funct, i_Opcode, i_ALUOp : decode inputs
//   i_RS, i_RT       : operands
//   o_ALUOp, o_Illegal : ALU operation code and undecodable-op flag
//   o_Stall          : freeze front of pipeline while the MDU works
//   o_HiLoSel, o_HiLo  : MFHI/MFLO result selection and value
//   o_DivByZero      : pulse in DONE after a zero-divisor divide
module alu_control_mdu
  import mips_pkg::*;
#(
  parameter int NBITS        = 32,
  parameter int ANBITS       = 6,
  parameter int NBITSCONTROL = 2,
  parameter int ALUOP        = 4
) (
  input  logic                    i_clk,
  input  logic                    i_reset_n,
  input  logic                    i_Valid,
  input  logic                    i_Flush,
  input  logic [ANBITS-1:0]       i_Funct,
  input  logic [ANBITS-1:0]       i_Opcode,
  input  logic [NBITSCONTROL-1:0] i_ALUOp,
  input  logic [NBITS-1:0]        i_RS,
  input  logic [NBITS-1:0]        i_RT,
  output logic [ALUOP-1:0]        o_ALUOp,
  output logic                    o_Illegal,
  output logic                    o_Stall,
  output logic                    o_HiLoSel,
  output logic [NBITS-1:0]        o_HiLo,
  output logic                    o_DivByZero
);

  localparam int CW = $clog2(NBITS + 1);

  function automatic logic [NBITS-1:0] abs_val(input logic signed [NBITS-1:0] v,
                                               input logic is_signed);
    return (is_signed && v < 0) ? NBITS'(-v) : NBITS'(v);
  endfunction

  function automatic logic [NBITS-1:0] cond_neg(input logic signed [NBITS-1:0] v,
                                                input logic neg);
    return neg ? NBITS'(-v) : NBITS'(v);
  endfunction

  function automatic logic [2*NBITS-1:0] cond_neg_w(input logic signed [2*NBITS-1:0] v,
                                                    input logic neg);
    return neg ? (2*NBITS)'(-v) : (2*NBITS)'(v);
  endfunction

  logic [5:0]       funct;
  logic [5:0]       opcode;
  logic [1:0]       cls;
  logic [3:0]       code;
  logic             is_rtype;
  logic             is_muldiv;
  logic             op_div;
  logic             op_signed;
  logic             start;

  mdu_state_t       state;
  logic [CW-1:0]    cnt;
  logic [NBITS-1:0] hi_q;
  logic [NBITS-1:0] lo_q;
  logic             div_op;
  logic             neg_q;
  logic             neg_r;
  logic             dbz_q;

  logic [NBITS-1:0]   a_mag;
  logic [NBITS-1:0]   b_mag;
  logic [NBITS-1:0]   res_hi;
  logic [NBITS-1:0]   res_lo;
  logic [2*NBITS-1:0] prod_fix;
  logic [NBITS-1:0]   quo_fix;
  logic [NBITS-1:0]   rem_fix;

  assign funct  = 6'(i_Funct);
  assign opcode = 6'(i_Opcode);
  assign cls    = 2'(i_ALUOp);

  always_comb begin
    code = ALU_ILLEGAL;
    case (cls)
      CLS_ADD: code = ALU_ADD;
      CLS_SUB: code = ALU_SUB;
      CLS_RTYPE: begin
        case (funct)
          F_ADD, F_ADDU:   code = ALU_ADD;
          F_SUB, F_SUBU:   code = ALU_SUB;
          F_AND:           code = ALU_AND;
          F_OR:            code = ALU_OR;
          F_NOR:           code = ALU_NOR;
          F_XOR:           code = ALU_XOR;
          F_SLT:           code = ALU_SLT;
          F_SLL, F_SLLV:   code = ALU_SLL;
          F_SRL, F_SRLV:   code = ALU_SRL;
          F_SRA:           code = ALU_SRA;
          F_MULT, F_MULTU, F_DIV, F_DIVU,
          F_MFHI, F_MTHI, F_MFLO, F_MTLO: code = ALU_ADD;
          default:         code = ALU_ILLEGAL;
        endcase
      end
      default: begin
        case (opcode)
          OP_SLTI: code = ALU_SLT;
          OP_ANDI: code = ALU_AND;
          OP_ORI:  code = ALU_OR;
          OP_XORI: code = ALU_XOR;
          default: code = ALU_ILLEGAL;
        endcase
      end
    endcase
  end

  assign o_ALUOp   = ALUOP'(code);
  assign o_Illegal = i_Valid && (code == ALU_ILLEGAL);

  assign is_rtype  = (cls == CLS_RTYPE);
  assign is_muldiv = (funct == F_MULT) || (funct == F_MULTU) ||
                     (funct == F_DIV)  || (funct == F_DIVU);
  assign op_div    = (funct == F_DIV)  || (funct == F_DIVU);
  assign op_signed = (funct == F_MULT) || (funct == F_DIV);
  assign start     = i_Valid && is_rtype && is_muldiv;

  assign a_mag = abs_val(i_RS, op_signed);
  assign b_mag = abs_val(i_RT, op_signed);

  mdu_datapath #(.NBITS(NBITS)) u_dp (
    .clk    (i_clk),
    .load   ((state == ST_IDLE) && start),
    .step   (state == ST_BUSY),
    .is_div (div_op),
    .a_mag  (a_mag),
    .b_mag  (b_mag),
    .nxt_hi (res_hi),
    .nxt_lo (res_lo)
  );

  assign prod_fix = cond_neg_w({res_hi, res_lo}, neg_q);
  assign quo_fix  = cond_neg(res_lo, neg_q);
  assign rem_fix  = cond_neg(res_hi, neg_r);

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      div_op <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      dbz_q  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            div_op <= op_div;
            neg_q  <= op_signed && (i_RS[NBITS-1] ^ i_RT[NBITS-1]);
            neg_r  <= op_signed && i_RS[NBITS-1];
            if (op_div && (i_RT == '0)) begin
              // Zero divisor skips the iteration entirely.
              hi_q  <= i_RS;
              lo_q  <= '1;
              dbz_q <= 1'b1;
              state <= ST_DONE;
            end else begin
              dbz_q <= 1'b0;
              cnt   <= CW'(NBITS);
              state <= ST_BUSY;
            end
          end else if (i_Valid && is_rtype && (funct == F_MTHI)) begin
            hi_q <= i_RS;
          end else if (i_Valid && is_rtype && (funct == F_MTLO)) begin
            lo_q <= i_RS;
          end
        end
        ST_BUSY: begin
          if (i_Flush) begin
            state <= ST_IDLE;
          end else begin
            cnt <= cnt - CW'(1);
            if (cnt == CW'(1)) begin
              if (div_op) begin
                hi_q <= rem_fix;
                lo_q <= quo_fix;
              end else begin
                {hi_q, lo_q} <= prod_fix;
              end
              state <= ST_DONE;
            end
          end
        end
        default: begin
          dbz_q <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Reset gates the combinational stall so a held MULT/DIV cannot keep it high.
  assign o_Stall     = i_reset_n && (((state == ST_IDLE) && start) || (state == ST_BUSY));
  assign o_DivByZero = (state == ST_DONE) && dbz_q;
  assign o_HiLoSel   = is_rtype && ((funct == F_MFHI) || (funct == F_MFLO));
  assign o_HiLo      = (funct == F_MFHI) ? hi_q : lo_q;

endmodule

// File: tb/tb_alu_control_mdu.sv
module tb_alu_control_mdu;
  import mips_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid;
  logic        flush;
  logic [5:0]  funct;
  logic [5:0]  opcode;
  logic [1:0]  cls;
  logic [31:0] rs;
  logic [31:0] rt;
  logic [3:0]  aluop;
  logic        illegal;
  logic        stall;
  logic        hilosel;
  logic [31:0] hilo;
  logic        dbz;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_q[$];
  string       tag_q[$];

  always #5 clk = ~clk;

  alu_control_mdu #(
    .NBITS(32), .ANBITS(6), .NBITSCONTROL(2), .ALUOP(4)
  ) dut (
    .i_clk       (clk),
    .i_reset_n   (rst_n),
    .i_Valid     (valid),
    .i_Flush     (flush),
    .i_Funct     (funct),
    .i_Opcode    (opcode),
    .i_ALUOp     (cls),
    .i_RS        (rs),
    .i_RT        (rt),
    .o_ALUOp     (aluop),
    .o_Illegal   (illegal),
    .o_Stall     (stall),
    .o_HiLoSel   (hilosel),
    .o_HiLo      (hilo),
    .o_DivByZero (dbz)
  );

  task automatic expect_val(input string tag, input logic [31:0] v);
    exp_q.push_back(v);
    tag_q.push_back(tag);
  endtask

  task automatic check(input logic [31:0] obs);
    logic [31:0] e;
    string       t;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty observed=%h expected=<none>", obs);
      return;
    end
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    assert (obs === e) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", t, obs, e);
    end
  endtask

  task automatic dec(input string tag, input logic [1:0] c, input logic [5:0] f,
                     input logic [5:0] op, input logic v,
                     input logic [3:0] exp_code, input logic exp_ill);
    expect_val({tag, "_code"}, {28'b0, exp_code});
    expect_val({tag, "_ill"}, {31'b0, exp_ill});
    @(negedge clk);
    valid = v; cls = c; funct = f; opcode = op; rs = '0; rt = '0;
    #1;
    check({28'b0, aluop});
    check({31'b0, illegal});
  endtask

  task automatic run_op(input string tag, input logic [5:0] f,
                        input logic [31:0] a, input logic [31:0] b,
                        input int exp_cyc, input logic exp_dbz,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int n;
    expect_val({tag, "_stall_cycles"}, 32'(exp_cyc));
    expect_val({tag, "_divbyzero"}, {31'b0, exp_dbz});
    expect_val({tag, "_hi"}, exp_hi);
    expect_val({tag, "_lo"}, exp_lo);
    @(negedge clk);
    valid = 1'b1; cls = CLS_RTYPE; funct = f; rs = a; rt = b;
    #1;
    n = 0;
    while (stall === 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
      #1;
    end
    check(32'(n));
    check({31'b0, dbz});
    valid = 1'b0;
    @(negedge clk);
    valid = 1'b1; funct = F_MFHI;
    #1;
    check(hilo);
    funct = F_MFLO;
    #1;
    check(hilo);
    valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; valid = 1'b0; flush = 1'b0; cls = CLS_RTYPE;
    funct = F_MFHI; opcode = '0; rs = '0; rt = '0;

    // reset state
    expect_val("reset_stall", 32'd0);
    expect_val("reset_dbz", 32'd0);
    expect_val("reset_hi", 32'd0);
    expect_val("reset_lo", 32'd0);
    #1;
    check({31'b0, stall});
    check({31'b0, dbz});
    check(hilo);
    funct = F_MFLO;
    #1;
    check(hilo);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // decode sweep
    dec("cls_add", CLS_ADD, 6'h3f, 6'h00, 1'b1, 4'b0010, 1'b0);
    dec("cls_sub", CLS_SUB, 6'h3f, 6'h00, 1'b1, 4'b0110, 1'b0);
    dec("add",  CLS_RTYPE, F_ADD,  '0, 1'b1, 4'b0010, 1'b0);
    dec("addu", CLS_RTYPE, F_ADDU, '0, 1'b1, 4'b0010, 1'b0);
    dec("sub",  CLS_RTYPE, F_SUB,  '0, 1'b1, 4'b0110, 1'b0);
    dec("subu", CLS_RTYPE, F_SUBU, '0, 1'b1, 4'b0110, 1'b0);
    dec("and",  CLS_RTYPE, F_AND,  '0, 1'b1, 4'b0000, 1'b0);
    dec("or",   CLS_RTYPE, F_OR,   '0, 1'b1, 4'b0001, 1'b0);
    dec("nor",  CLS_RTYPE, F_NOR,  '0, 1'b1, 4'b1100, 1'b0);
    dec("xor",  CLS_RTYPE, F_XOR,  '0, 1'b1, 4'b1101, 1'b0);
    dec("slt",  CLS_RTYPE, F_SLT,  '0, 1'b1, 4'b0111, 1'b0);
    dec("sll",  CLS_RTYPE, F_SLL,  '0, 1'b1, 4'b0011, 1'b0);
    dec("sllv", CLS_RTYPE, F_SLLV, '0, 1'b1, 4'b0011, 1'b0);
    dec("srl",  CLS_RTYPE, F_SRL,  '0, 1'b1, 4'b0100, 1'b0);
    dec("srlv", CLS_RTYPE, F_SRLV, '0, 1'b1, 4'b0100, 1'b0);
    dec("sra",  CLS_RTYPE, F_SRA,  '0, 1'b1, 4'b1001, 1'b0);
    dec("mult", CLS_RTYPE, F_MULT, '0, 1'b0, 4'b0010, 1'b0);
    dec("multu",CLS_RTYPE, F_MULTU,'0, 1'b0, 4'b0010, 1'b0);
    dec("div",  CLS_RTYPE, F_DIV,  '0, 1'b0, 4'b0010, 1'b0);
    dec("divu", CLS_RTYPE, F_DIVU, '0, 1'b0, 4'b0010, 1'b0);
    dec("mfhi", CLS_RTYPE, F_MFHI, '0, 1'b1, 4'b0010, 1'b0);
    dec("mthi", CLS_RTYPE, F_MTHI, '0, 1'b1, 4'b0010, 1'b0);
    dec("mflo", CLS_RTYPE, F_MFLO, '0, 1'b1, 4'b0010, 1'b0);
    dec("mtlo", CLS_RTYPE, F_MTLO, '0, 1'b1, 4'b0010, 1'b0);
    dec("slti", CLS_IMM, '0, OP_SLTI, 1'b1, 4'b0111, 1'b0);
    dec("andi", CLS_IMM, '0, OP_ANDI, 1'b1, 4'b0000, 1'b0);
    dec("ori",  CLS_IMM, '0, OP_ORI,  1'b1, 4'b0001, 1'b0);
    dec("xori", CLS_IMM, '0, OP_XORI, 1'b1, 4'b1101, 1'b0);
    dec("bad_funct",        CLS_RTYPE, 6'h3f, '0, 1'b1, 4'b1111, 1'b1);
    dec("bad_funct_bubble", CLS_RTYPE, 6'h3f, '0, 1'b0, 4'b1111, 1'b0);
    dec("bad_opcode",       CLS_IMM, '0, 6'h3f, 1'b1, 4'b1111, 1'b1);
    @(negedge clk);
    valid = 1'b0;

    // MFHI/MFLO selection flag
    expect_val("hilosel_mfhi", 32'd1);
    @(negedge clk);
    cls = CLS_RTYPE; funct = F_MFHI;
    #1;
    check({31'b0, hilosel});

    // multiply / divide results
    run_op("multu_max", F_MULTU, 32'hFFFF_FFFF, 32'h0000_0002, 33, 1'b0, 32'h0000_0001, 32'hFFFF_FFFE);
    run_op("mult_neg",  F_MULT,  32'hFFFF_FFFD, 32'h0000_0005, 33, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
    run_op("div_neg",   F_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 33, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("div_negdiv",F_DIV,   32'h0000_0007, 32'hFFFF_FFFE, 33, 1'b0, 32'h0000_0001, 32'hFFFF_FFFD);
    run_op("divu_zero", F_DIVU,  32'h1234_5678, 32'h0000_0000, 1,  1'b1, 32'h1234_5678, 32'hFFFF_FFFF);
    run_op("div_ovf",   F_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 33, 1'b0, 32'h0000_0000, 32'h8000_0000);

    // asynchronous reset in the middle of an operation
    expect_val("mid_busy_stall", 32'd1);
    expect_val("mid_reset_stall", 32'd0);
    expect_val("mid_reset_dbz", 32'd0);
    expect_val("mid_reset_hi", 32'd0);
    expect_val("mid_reset_lo", 32'd0);
    @(negedge clk);
    valid = 1'b1; cls = CLS_RTYPE; funct = F_MULTU; rs = 32'hFFFF_FFFF; rt = 32'h2;
    repeat (10) @(negedge clk);
    #1;
    check({31'b0, stall});
    rst_n = 1'b0;
    #1;
    check({31'b0, stall});
    check({31'b0, dbz});
    funct = F_MFHI;
    #1;
    check(hilo);
    funct = F_MFLO;
    #1;
    check(hilo);
    valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // MTHI/MTLO then flush mid-operation keeps HI/LO
    expect_val("flush_busy_stall", 32'd1);
    expect_val("flush_idle_stall", 32'd0);
    expect_val("flush_hi_kept", 32'hAAAA_5555);
    expect_val("flush_lo_kept", 32'h1234_ABCD);
    @(negedge clk);
    valid = 1'b1; cls = CLS_RTYPE; funct = F_MTHI; rs = 32'hAAAA_5555;
    @(negedge clk);
    funct = F_MTLO; rs = 32'h1234_ABCD;
    @(negedge clk);
    funct = F_DIVU; rs = 32'd100; rt = 32'd7;
    repeat (10) @(negedge clk);
    #1;
    check({31'b0, stall});
    valid = 1'b0; flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    #1;
    check({31'b0, stall});
    valid = 1'b1; funct = F_MFHI;
    #1;
    check(hilo);
    funct = F_MFLO;
    #1;
    check(hilo);
    valid = 1'b0;

    // recovery after flush
    run_op("divu_after_flush", F_DIVU, 32'd100, 32'd7, 33, 1'b0, 32'd2, 32'd14);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
